// File: rtl/xport_eth_pkg.sv
// Shared constants for the CHDR-over-Ethernet transmit framer.
package xport_eth_pkg;

  // Route value layout: {remote MAC, remote IP, remote UDP port, local UDP port}
  localparam int unsigned RV_RMAC_LSB  = 64;
  localparam int unsigned RV_MAC_W     = 48;
  localparam int unsigned RV_RIP_LSB   = 32;
  localparam int unsigned RV_IP_W      = 32;
  localparam int unsigned RV_RPORT_LSB = 16;
  localparam int unsigned RV_LPORT_LSB = 0;
  localparam int unsigned RV_PORT_W    = 16;

  localparam int unsigned ETH_HDR_BYTES  = 42;
  // Header bytes carried by the pure-header beats; bytes 40..41 (UDP checksum,
  // always zero) ride in the first body beat as its residual.
  localparam int unsigned HDR_BEAT_BYTES = 40;
  localparam int unsigned HDR_BEATS      = HDR_BEAT_BYTES / 8;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;
  localparam int unsigned IP_LEN_OVH     = 28;  // IPv4 + UDP header bytes
  localparam int unsigned UDP_LEN_OVH    = 8;

  // FSM state encoding
  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StCalc = 3'd1;
  localparam logic [2:0] StHdr  = 3'd2;
  localparam logic [2:0] StBody = 3'd3;
  localparam logic [2:0] StTail = 3'd4;

  // One end-around-carry fold of a 32-bit one's-complement accumulator.
  function automatic logic [16:0] csum_fold(input logic [31:0] s);
    return 17'(s[15:0]) + 17'(s[31:16]);
  endfunction

endpackage

// File: rtl/ipv4_csum.sv
// Combinational IPv4 header checksum for the fixed framer header.
module ipv4_csum
  import xport_eth_pkg::*;
#(
  parameter int unsigned TTL = 64
) (
  input  logic [15:0] total_len,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  output logic [15:0] csum
);

  logic [31:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // Sum the ten header halfwords (ident and checksum fields are zero), fold, invert.
  always_comb begin
    sum = 32'({IP_VER_IHL, 8'h00}) + 32'(total_len) + 32'(IP_FLAGS_DF) +
          32'({8'(TTL), IP_PROTO_UDP}) +
          32'(src_ip[31:16]) + 32'(src_ip[15:0]) +
          32'(dst_ip[31:16]) + 32'(dst_ip[15:0]);
    fold1 = csum_fold(sum);
    // Ten halfwords leave at most a small carry, so the second fold cannot overflow.
    fold2 = fold1[15:0] + 16'(fold1[16]);
    csum  = ~fold2;
  end

endmodule

// File: rtl/xport_eth_framer.sv
// Transmit framer: wraps each CHDR packet in an Ethernet/IPv4/UDP header.
module xport_eth_framer
  import xport_eth_pkg::*;
#(
  parameter int unsigned CHDR_W = 64,   // only 64 is supported
  parameter int unsigned VAL_W  = 112,
  parameter int unsigned TTL    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CHDR_W-1:0] x2e_tdata,
  input  logic [VAL_W-1:0]  x2e_tuser,
  input  logic              x2e_tvalid,
  input  logic              x2e_tlast,
  output logic              x2e_tready,
  input  logic [47:0]       local_mac,
  input  logic [31:0]       local_ip,
  output logic [63:0]       eth_tdata,
  output logic [7:0]        eth_tkeep,
  output logic              eth_tvalid,
  output logic              eth_tlast,
  input  logic              eth_tready
);

  logic [2:0]       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [15:0]      len_q, len_d;
  logic [VAL_W-1:0] rv_q, rv_d;
  logic [47:0]      lmac_q, lmac_d;
  logic [31:0]      lip_q, lip_d;
  logic [15:0]      csum_q, csum_d;
  logic [15:0]      res_q, res_d;

  logic [47:0] rmac;
  logic [31:0] rip;
  logic [15:0] rport, lport;
  logic [15:0] tot_len, udp_len, csum_calc;
  logic [HDR_BEAT_BYTES*8-1:0] hdr_be;
  logic [63:0] hdr_words [HDR_BEATS];

  assign rmac    = rv_q[RV_RMAC_LSB +: RV_MAC_W];
  assign rip     = rv_q[RV_RIP_LSB +: RV_IP_W];
  assign rport   = rv_q[RV_RPORT_LSB +: RV_PORT_W];
  assign lport   = rv_q[RV_LPORT_LSB +: RV_PORT_W];
  assign tot_len = len_q + 16'(IP_LEN_OVH);
  assign udp_len = len_q + 16'(UDP_LEN_OVH);

  // local_ip is taken live here; it is only consumed while in CALC.
  ipv4_csum #(
    .TTL(TTL)
  ) u_csum (
    .total_len(tot_len),
    .src_ip   (local_ip),
    .dst_ip   (rip),
    .csum     (csum_calc)
  );

  // Header bytes 0..39 in network order (byte 0 in the top bits), mapped onto beat lanes.
  always_comb begin
    hdr_be = {rmac, lmac_q, ETHERTYPE_IPV4, IP_VER_IHL, 8'h00, tot_len, 16'h0000,
              IP_FLAGS_DF, 8'(TTL), IP_PROTO_UDP, csum_q, lip_q, rip, lport, rport, udp_len};
    for (int w = 0; w < HDR_BEATS; w++) begin
      hdr_words[w] = '0;
    end
    for (int b = 0; b < HDR_BEAT_BYTES; b++) begin
      hdr_words[b/8][8*(b%8) +: 8] = hdr_be[HDR_BEAT_BYTES*8-1-8*b -: 8];
    end
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    rv_d    = rv_q;
    lmac_d  = lmac_q;
    lip_d   = lip_q;
    csum_d  = csum_q;
    res_d   = res_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        // Peek word 0 for the length; it is consumed later in BODY.
        if (x2e_tvalid) begin
          len_d   = x2e_tdata[31:16];
          rv_d    = x2e_tuser;
          state_d = StCalc;
        end
      end
      StCalc: begin
        csum_d  = csum_calc;
        lmac_d  = local_mac;
        lip_d   = local_ip;
        state_d = StHdr;
      end
      StHdr: begin
        if (eth_tready) begin
          if (cnt_q == 3'(HDR_BEATS - 1)) begin
            res_d   = 16'h0000;  // UDP checksum bytes 40..41
            state_d = StBody;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      StBody: begin
        if (x2e_tvalid && eth_tready) begin
          res_d = x2e_tdata[63:48];
          if (x2e_tlast) begin
            state_d = StTail;
          end
        end
      end
      StTail: begin
        if (eth_tready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output beat selection; body beats shift input by two byte lanes.
  always_comb begin
    eth_tvalid = 1'b0;
    eth_tlast  = 1'b0;
    eth_tdata  = '0;
    eth_tkeep  = '0;
    x2e_tready = 1'b0;
    case (state_q)
      StHdr: begin
        eth_tvalid = 1'b1;
        eth_tdata  = hdr_words[cnt_q];
        eth_tkeep  = 8'hFF;
      end
      StBody: begin
        eth_tvalid = x2e_tvalid;
        eth_tdata  = {x2e_tdata[47:0], res_q};
        eth_tkeep  = 8'hFF;
        x2e_tready = eth_tready;
      end
      StTail: begin
        eth_tvalid = 1'b1;
        eth_tdata  = {48'h0, res_q};
        eth_tkeep  = 8'h03;
        eth_tlast  = 1'b1;
      end
      default: ;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      rv_q    <= '0;
      lmac_q  <= '0;
      lip_q   <= '0;
      csum_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      rv_q    <= rv_d;
      lmac_q  <= lmac_d;
      lip_q   <= lip_d;
      csum_q  <= csum_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_xport_eth_framer.sv
// Self-checking bench for xport_eth_framer.
module tb_xport_eth_framer;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  x2e_tdata;
  logic [111:0] x2e_tuser;
  logic         x2e_tvalid, x2e_tlast, x2e_tready;
  logic [47:0]  local_mac;
  logic [31:0]  local_ip;
  logic [63:0]  eth_tdata;
  logic [7:0]   eth_tkeep;
  logic         eth_tvalid, eth_tlast, eth_tready;

  always #5 clk = ~clk;

  xport_eth_framer dut (
    .clk       (clk),
    .rst       (rst),
    .x2e_tdata (x2e_tdata),
    .x2e_tuser (x2e_tuser),
    .x2e_tvalid(x2e_tvalid),
    .x2e_tlast (x2e_tlast),
    .x2e_tready(x2e_tready),
    .local_mac (local_mac),
    .local_ip  (local_ip),
    .eth_tdata (eth_tdata),
    .eth_tkeep (eth_tkeep),
    .eth_tvalid(eth_tvalid),
    .eth_tlast (eth_tlast),
    .eth_tready(eth_tready)
  );

  int total = 0;
  int bad   = 0;

  // Source stream (one entry per CHDR word) and captured output beats
  logic [63:0]  src_w[$];
  bit           src_l[$];
  logic [111:0] src_u[$];
  logic [63:0]  got_d[$];
  logic [7:0]   got_k[$];
  bit           got_l[$];
  int           gap_q[$];
  int           first_lat;
  logic [7:0]   mq[$];

  typedef struct {
    string        name;
    int           nwords;
    logic [15:0]  len;
    logic [111:0] tuser;
    logic [47:0]  lmac;
    logic [31:0]  lip;
    int           exp_beats;
    logic [15:0]  exp_tot;
    logic [15:0]  exp_csum;
    logic [15:0]  exp_udp;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic make_packet(input int n, input logic [15:0] len, input logic [111:0] tu);
    logic [63:0] w;
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom};
      if (i == 0) w[31:16] = len;
      src_w.push_back(w);
      src_l.push_back(i == n - 1);
      src_u.push_back(tu);
    end
  endtask

  task automatic clear_src();
    src_w.delete();
    src_l.delete();
    src_u.delete();
  endtask

  // Drive the whole source queue, collect beats, check stalled beats hold steady.
  task automatic run_stream(input int rdy_pct, input int npkt);
    int widx = 0, nlast = 0, cyc = 0, gap = 0;
    bit stalled = 0, seen = 0, in_gap = 0;
    logic [63:0] pd;
    logic [7:0]  pk;
    bit          pl;
    got_d.delete(); got_k.delete(); got_l.delete(); gap_q.delete();
    first_lat = -1;
    pd = '0; pk = '0; pl = 0;
    while (nlast < npkt && cyc < 5000) begin
      if (widx < src_w.size()) begin
        x2e_tvalid = 1'b1;
        x2e_tdata  = src_w[widx];
        x2e_tlast  = src_l[widx];
        x2e_tuser  = src_u[widx];
      end else begin
        x2e_tvalid = 1'b0;
        x2e_tlast  = 1'b0;
      end
      eth_tready = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      if (stalled) begin
        total++;
        if (!eth_tvalid || eth_tdata !== pd || eth_tkeep !== pk || eth_tlast !== pl) begin
          bad++;
          $display("FAIL hold cyc %0d: got v=%b d=%h k=%h l=%b want v=1 d=%h k=%h l=%b",
                   cyc, eth_tvalid, eth_tdata, eth_tkeep, eth_tlast, pd, pk, pl);
        end
      end
      if (eth_tvalid && !seen) begin
        first_lat = cyc;
        seen = 1;
      end
      if (in_gap) begin
        if (eth_tvalid) begin
          gap_q.push_back(gap);
          in_gap = 0;
        end else begin
          gap++;
        end
      end
      if (eth_tvalid && eth_tready) begin
        got_d.push_back(eth_tdata);
        got_k.push_back(eth_tkeep);
        got_l.push_back(eth_tlast);
        if (eth_tlast) begin
          nlast++;
          in_gap = 1;
          gap = 0;
        end
      end
      if (x2e_tvalid && x2e_tready) widx++;
      stalled = eth_tvalid && !eth_tready;
      pd = eth_tdata; pk = eth_tkeep; pl = eth_tlast;
      @(posedge clk);
      #1;
      cyc++;
    end
    x2e_tvalid = 1'b0;
    x2e_tlast  = 1'b0;
    if (nlast < npkt) begin
      total++;
      bad++;
      $display("FAIL stream timeout: got %0d frames want %0d", nlast, npkt);
    end
  endtask

  task automatic put(input logic [63:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) mq.push_back(v[8*i +: 8]);
  endtask

  // Reference: build the frame as a byte list from the header rules, then compare beats.
  task automatic check_frame(input string nm, input int beat0, input int w0, input int n);
    logic [111:0] tu;
    logic [15:0]  len, cs;
    logic [31:0]  sum;
    logic [63:0]  ed, m;
    logic [7:0]   ek;
    bit           el;
    int           ne, nerr, firstb, idx;
    tu = src_u[w0];
    len = src_w[w0][31:16];
    mq.delete();
    put(tu[111:64], 6); put(local_mac, 6); put(64'h0800, 2);
    put(64'h45, 1); put(64'h0, 1); put(64'(28 + len), 2); put(64'h0, 2); put(64'h4000, 2);
    put(64'd64, 1); put(64'd17, 1); put(64'h0, 2); put(local_ip, 4); put(tu[63:32], 4);
    put(tu[15:0], 2); put(tu[31:16], 2); put(64'(8 + len), 2); put(64'h0, 2);
    sum = 0;
    for (int i = 14; i < 34; i += 2) sum += {16'h0, mq[i], mq[i+1]};
    sum = (sum & 32'hFFFF) + (sum >> 16);
    sum = (sum & 32'hFFFF) + (sum >> 16);
    cs = ~sum[15:0];
    mq[24] = cs[15:8];
    mq[25] = cs[7:0];
    for (int w = w0; w < w0 + n; w++)
      for (int j = 0; j < 8; j++) mq.push_back(src_w[w][8*j +: 8]);
    ne = (mq.size() + 7) / 8;
    nerr = 0;
    firstb = -1;
    for (int b = 0; b < ne; b++) begin
      ed = '0; ek = '0; m = '0;
      for (int j = 0; j < 8; j++) begin
        if (8*b + j < mq.size()) begin
          ed[8*j +: 8] = mq[8*b + j];
          ek[j] = 1'b1;
          m[8*j +: 8] = 8'hFF;
        end
      end
      el = (b == ne - 1);
      idx = beat0 + b;
      if (idx >= got_d.size() || got_k[idx] !== ek || got_l[idx] !== el ||
          ((got_d[idx] ^ ed) & m) !== 64'h0) begin
        if (firstb < 0) firstb = b;
        nerr++;
      end
    end
    total++;
    if (nerr != 0) begin
      bad++;
      $display("FAIL frame %s: got %0d bad beats (first at %0d) want 0 of %0d", nm, nerr, firstb, ne);
    end
  endtask

  function automatic logic [7:0] gb(input int n);
    return got_d[n/8][8*(n%8) +: 8];
  endfunction

  initial begin
    int boff, woff, npk, nacc, widx;
    int lens[$];
    logic [111:0] tu;

    vecs[0] = '{"basic", 2, 16'd16, {48'h001122334455, 32'hC0A8010A, 16'hC000, 16'hC001},
                48'h02AABBCCDDEE, 32'hC0A80102, 8, 16'h002C, 16'hB764, 16'h0018};
    vecs[1] = '{"min", 1, 16'd8, {48'h001122334455, 32'hC0A8010A, 16'hC000, 16'hC001},
                48'h02AABBCCDDEE, 32'hC0A80102, 7, 16'h0024, 16'hB76C, 16'h0010};
    vecs[2] = '{"lenmis", 2, 16'd32, {48'h001122334455, 32'hC0A8010A, 16'hC000, 16'hC001},
                48'h02AABBCCDDEE, 32'hC0A80102, 8, 16'h003C, 16'hB754, 16'h0028};
    vecs[3] = '{"ten", 3, 16'd24, {48'hA0B1C2D3E4F5, 32'h0A000001, 16'h1234, 16'h5678},
                48'h020000000001, 32'h0A000002, 9, 16'h0034, 16'h26B7, 16'h0020};

    rst = 1'b1;
    x2e_tvalid = 1'b0; x2e_tlast = 1'b0; x2e_tdata = '0; x2e_tuser = '0;
    eth_tready = 1'b0;
    local_mac = 48'h02AABBCCDDEE;
    local_ip  = 32'hC0A80102;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset tvalid", eth_tvalid, 0);
    chk("reset tlast", eth_tlast, 0);
    chk("reset tdata", eth_tdata, 0);
    chk("reset tkeep", eth_tkeep, 0);
    chk("reset x2e_tready", x2e_tready, 0);
    @(posedge clk);
    #1;

    // Directed vectors with hand-computed header fields
    for (int v = 0; v < 4; v++) begin
      clear_src();
      local_mac = vecs[v].lmac;
      local_ip  = vecs[v].lip;
      make_packet(vecs[v].nwords, vecs[v].len, vecs[v].tuser);
      run_stream(100, 1);
      chk({vecs[v].name, " latency"}, first_lat, 2);
      chk({vecs[v].name, " beats"}, got_d.size(), vecs[v].exp_beats);
      if (got_d.size() >= 6) begin
        chk({vecs[v].name, " ip total len"}, {gb(16), gb(17)}, vecs[v].exp_tot);
        chk({vecs[v].name, " ip csum"}, {gb(24), gb(25)}, vecs[v].exp_csum);
        chk({vecs[v].name, " udp len"}, {gb(38), gb(39)}, vecs[v].exp_udp);
        chk({vecs[v].name, " beat5"}, got_d[5], {src_w[0][47:0], 16'h0000});
        chk({vecs[v].name, " last keep"}, got_k[got_k.size()-1], 8'h03);
      end
      check_frame(vecs[v].name, 0, 0, vecs[v].nwords);
    end

    // 64-word packet under 50% output backpressure
    local_mac = 48'h02AABBCCDDEE;
    local_ip  = 32'hC0A80102;
    clear_src();
    make_packet(64, 16'd512, {$urandom, $urandom, $urandom, $urandom});
    run_stream(50, 1);
    chk("bp64 beats", got_d.size(), 70);
    check_frame("bp64", 0, 0, 64);

    // Back-to-back packets, each with its own route value
    clear_src();
    lens.delete();
    for (int p = 0; p < 3; p++) begin
      npk = $urandom_range(1, 6);
      lens.push_back(npk);
      make_packet(npk, 16'(8 * npk), {$urandom, $urandom, $urandom, $urandom});
    end
    run_stream(100, 3);
    chk("b2b gap count", gap_q.size(), 2);
    for (int g = 0; g < gap_q.size(); g++) chk("b2b gap", gap_q[g], 2);
    boff = 0; woff = 0;
    for (int p = 0; p < 3; p++) begin
      check_frame("b2b", boff, woff, lens[p]);
      boff += lens[p] + 6;
      woff += lens[p];
    end

    // Random mix with random backpressure
    clear_src();
    lens.delete();
    for (int p = 0; p < 4; p++) begin
      npk = $urandom_range(1, 12);
      lens.push_back(npk);
      make_packet(npk, 16'(8 * npk), {$urandom, $urandom, $urandom, $urandom});
    end
    run_stream(70, 4);
    boff = 0; woff = 0;
    for (int p = 0; p < 4; p++) begin
      check_frame("mix", boff, woff, lens[p]);
      boff += lens[p] + 6;
      woff += lens[p];
    end

    // Reset while in BODY, then a clean frame
    clear_src();
    make_packet(8, 16'd64, {$urandom, $urandom, $urandom, $urandom});
    nacc = 0; widx = 0;
    for (int c = 0; c < 100 && nacc < 7; c++) begin
      x2e_tvalid = (widx < src_w.size());
      if (widx < src_w.size()) begin
        x2e_tdata = src_w[widx];
        x2e_tlast = src_l[widx];
        x2e_tuser = src_u[widx];
      end
      eth_tready = 1'b1;
      @(negedge clk);
      if (eth_tvalid && eth_tready) nacc++;
      if (x2e_tvalid && x2e_tready) widx++;
      @(posedge clk);
      #1;
    end
    chk("pre-reset beats", nacc, 7);
    rst = 1'b1;
    x2e_tvalid = 1'b0;
    x2e_tlast = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst tvalid", eth_tvalid, 0);
    chk("midrst tlast", eth_tlast, 0);
    chk("midrst tdata", eth_tdata, 0);
    chk("midrst tkeep", eth_tkeep, 0);
    chk("midrst x2e_tready", x2e_tready, 0);
    @(posedge clk);
    #1;
    clear_src();
    tu = {48'h0A0B0C0D0E0F, 32'h0A010203, 16'h4321, 16'h8765};
    make_packet(3, 16'd24, tu);
    run_stream(100, 1);
    chk("post-reset beats", got_d.size(), 9);
    check_frame("post-reset", 0, 0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xport_eth_framer.md
Name: xport_eth_framer

Overview:
- Transmit-side framer for the CHDR-over-Ethernet transport.
- Consumes the x2e CHDR stream plus its per-packet route value (the looked-up remote endpoint) and emits a complete Ethernet/IPv4/UDP frame on a 64-bit byte-lane stream toward the MAC.
- It is the egress counterpart of the ingress path that parses UDP frames and inserts route values into the route table.

Parameters:
- CHDR_W, 64, CHDR word width; only 64 is supported.
- VAL_W, 112, route value width; layout is fixed in the package.
- TTL, 64, IPv4 time-to-live.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- x2e_tdata  in  64  CHDR payload words.
- x2e_tuser  in  112  route value; sampled with the first beat of each packet.
- x2e_tvalid  in  1  AXI-Stream valid.
- x2e_tlast  in  1  marks the last CHDR word.
- x2e_tready  out  1  ready back to the CHDR source.
- local_mac  in  48  source MAC; quasi-static.
- local_ip  in  32  source IPv4 address; quasi-static.
- eth_tdata  out  64  frame bytes; byte n of a beat is on [8n+7:8n].
- eth_tkeep  out  8  byte enables; always contiguous from bit 0.
- eth_tvalid  out  1  AXI-Stream valid.
- eth_tlast  out  1  marks the last beat of the frame.
- eth_tready  in  1  ready from the MAC.

Behaviour:
- Reset state: eth_tvalid=0, eth_tlast=0, eth_tdata=0, eth_tkeep=0, x2e_tready=0, FSM in IDLE.
- Route value layout: tuser[111:64]=remote MAC, [63:32]=remote IP, [31:16]=remote UDP port, [15:0]=local UDP port.
- CHDR length: L = first word bits [31:16], in bytes. L is a multiple of 8 and at least 8.
- Header contents (42 bytes, network byte order, byte 0 first):
  - Ethernet: remote MAC, local_mac, ethertype 0x0800.
  - IPv4: 0x45, TOS 0, total length 28+L, ident 0, flags/fragment 0x4000, TTL, protocol 17, checksum, local_ip, remote IP.
  - UDP: local port as source, remote port as destination, length 8+L, checksum 0.
- IPv4 checksum: 16-bit one's-complement sum of the 10 header halfwords with the checksum field taken as 0. Carries are folded twice, then the result is inverted.
- FSM states:
  - IDLE: when x2e_tvalid=1, peek word 0 without consuming it. Latch L and tuser, then go to CALC.
  - CALC: one cycle to register the checksum, then go to HDR.
  - HDR: beats W0..W4 carry header bytes 0..39. An internal counter (0..4) advances on eth_tvalid&eth_tready.
  - BODY: each beat is the previous word's residual bytes 6..7 in lanes 0..1, followed by the current input bytes 0..5. The first BODY beat (W5) uses header bytes 40..41 as its residual. The input is accepted on a beat only when the output is accepted: x2e_tready = eth_tready in BODY, 0 in all other states. When the accepted input has tlast, go to TAIL.
  - TAIL: one beat carrying the final residual 2 bytes, eth_tkeep=0x03, eth_tlast=1. On acceptance go to IDLE.
- Beat count: an N-word CHDR packet yields N+6 beats. Every beat except the last has eth_tkeep=0xFF.
- Latency: first eth_tvalid two cycles after x2e_tvalid rises in IDLE. Throughput is one beat per cycle under no backpressure, plus 2 dead cycles (IDLE, CALC) per frame.
- Backpressure: while eth_tvalid=1 and eth_tready=0, eth_tdata, eth_tkeep and eth_tlast stay stable and no input is consumed.
- Length mismatch: input tlast always governs framing. If L disagrees with the actual word count, the header fields still use L. There is no error flag.
- Quasi-static inputs: local_mac and local_ip are sampled in CALC; changes mid-frame do not affect the current frame.
- Reset mid-frame: return to IDLE immediately with all outputs cleared. The partial frame is left unterminated and the consumer is responsible for dropping it.

Decomposition:
- Package xport_eth_pkg holds:
  - route-value field offsets and widths;
  - ETH_HDR_BYTES=42, ETHERTYPE_IPV4=16'h0800, IP_PROTO_UDP=8'd17, IP_FLAGS_DF=16'h4000;
  - FSM state encoding.
- Sub-module ipv4_csum: combinational header-sum plus fold, registered by the parent in CALC.

Test Plan:
- Basic frame, no backpressure:
  - Stimulus: L=16 (2 words), remote MAC 001122334455, remote IP C0A8010A, remote port C000, local port C001, local_mac 02AABBCCDDEE, local_ip C0A80102, TTL=64.
  - Required: 8 beats; IP total length 0x002C; checksum 0xB764; UDP length 0x0018; last beat tkeep=0x03.
- Random eth_tready at 50% on a 64-word packet: frame is byte-identical to the no-backpressure frame, and held data is stable on every stalled cycle.
- Back-to-back packets with different tuser: each frame carries its own route value, with exactly 2 idle cycles between frames.
- Minimum packet, L=8: 7 beats; beat 5 holds header bytes 40..41 plus CHDR bytes 0..5; beat 6 has tkeep=0x03.
- Reset asserted during BODY: all outputs are 0 on the next cycle. A following packet is framed correctly from W0.
- L field=32 but tlast on word 2: 8 beats are emitted and the IP total length still reads 60.
